// File: rtl/mul_issue_wb_ctrl.sv
// mul_issue_wb_ctrl
// Issue/writeback sequencer for an external fixed-latency multiplier.
// Multiply requests are accepted over a valid/ready handshake, registered
// into the multiplier and tracked by destination tag. Products are placed in
// a small result FIFO and offered to writeback over a second handshake.
// A credit counter bounds outstanding work to the FIFO depth, so a product
// is never dropped under writeback backpressure.
//
// Ports:
//   CLK, rst_n        clock (rising edge), asynchronous active-low reset
//   flush             synchronous kill of queued and in-flight operations
//   req_*             execute-stage request (valid/ready, rs1, rs2, funct3, rd)
//   mul_multiplier    registered rs1 to the multiplier
//   mul_multiplicand  registered rs2 to the multiplier
//   mul_funct         registered funct3[1:0]
//   mul_valid_in      one-cycle issue pulse
//   mul_data_out      multiplier result, valid MUL_LAT cycles after issue
//   wb_*              writeback result (valid/ready, data, rd)
//   busy              any accepted request not yet popped at writeback
module mul_issue_wb_ctrl #(
    parameter int XLEN     = 32,
    parameter int TAG_W    = 5,
    parameter int MUL_LAT  = 1,
    parameter int RQ_DEPTH = 4
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [XLEN-1:0]  req_rs1,
    input  logic [XLEN-1:0]  req_rs2,
    input  logic [2:0]       req_funct3,
    input  logic [TAG_W-1:0] req_rd,
    output logic [XLEN-1:0]  mul_multiplier,
    output logic [XLEN-1:0]  mul_multiplicand,
    output logic [1:0]       mul_funct,
    output logic             mul_valid_in,
    input  logic [XLEN-1:0]  mul_data_out,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [XLEN-1:0]  wb_data,
    output logic [TAG_W-1:0] wb_rd,
    output logic             busy
);

    localparam int PTR_W = $clog2(RQ_DEPTH);
    localparam int CNT_W = $clog2(RQ_DEPTH + 1);

    typedef struct packed {
        logic [TAG_W-1:0] rd;
        logic [XLEN-1:0]  data;
    } res_t;

    logic [CNT_W-1:0]              cnt;
    logic                          accept;
    logic                          pop;
    logic                          fifo_wr;
    logic                          fifo_empty;
    logic                          fifo_full;
    logic [MUL_LAT:0]              vld_pipe;
    logic [MUL_LAT:0][TAG_W-1:0]   rd_pipe;
    res_t                          fifo_mem [RQ_DEPTH];
    // Extra MSB distinguishes full from empty when the indices match.
    logic [PTR_W:0]                wr_ptr;
    logic [PTR_W:0]                rd_ptr;
    logic                          unused_funct3_msb;

    // funct3[2] only separates multiply from divide; divides never arrive here.
    assign unused_funct3_msb = req_funct3[2];

    // Credits come from registered state only, so ready never waits on wb_ready.
    assign req_ready  = (cnt < CNT_W'(RQ_DEPTH)) & ~flush;
    assign accept     = req_valid & req_ready;
    assign busy       = (cnt != '0);

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign wb_valid   = ~fifo_empty;
    assign wb_data    = fifo_mem[rd_ptr[PTR_W-1:0]].data;
    assign wb_rd      = fifo_mem[rd_ptr[PTR_W-1:0]].rd;
    assign pop        = wb_valid & wb_ready;
    // The last pipe stage lines up with the cycle the multiplier holds its product.
    assign fifo_wr    = vld_pipe[MUL_LAT] & ~flush;

    // Credit counter: accepted and not yet popped at writeback.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (accept && !pop) begin
            cnt <= cnt + CNT_W'(1);
        end else if (!accept && pop) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Issue registers; operands hold their last value between issues.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            mul_valid_in     <= 1'b0;
            mul_multiplier   <= '0;
            mul_multiplicand <= '0;
            mul_funct        <= '0;
        end else begin
            mul_valid_in <= accept;
            if (accept) begin
                mul_multiplier   <= req_rs1;
                mul_multiplicand <= req_rs2;
                mul_funct        <= req_funct3[1:0];
            end
        end
    end

    // Tag pipe: stage 0 is loaded alongside the issue pulse.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            rd_pipe  <= '0;
        end else if (flush) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= accept;
            rd_pipe[0]  <= req_rd;
            for (int i = 1; i <= MUL_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                rd_pipe[i]  <= rd_pipe[i-1];
            end
        end
    end

    // Result FIFO pointers. Read advances before write logically, so a write
    // into a full FIFO is fine when the head is popped in the same cycle.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (fifo_wr) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (pop)     rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RQ_DEPTH; i++) fifo_mem[i] <= '0;
        end else if (fifo_wr) begin
            fifo_mem[wr_ptr[PTR_W-1:0]] <= '{rd: rd_pipe[MUL_LAT], data: mul_data_out};
        end
    end

    // Credits bound outstanding work, so this can only fire on a credit bug.
    assert property (@(posedge CLK) disable iff (!rst_n)
        !(fifo_wr && fifo_full && !pop));

endmodule

// File: tb/tb_mul_issue_wb_ctrl.sv
module tb_mul_issue_wb_ctrl;

    localparam int XLEN     = 32;
    localparam int TAG_W    = 5;
    localparam int RQ_DEPTH = 4;
    localparam int LAT_WB   = 3; // accept cycle to first wb_valid cycle

    logic             CLK, rst_n, flush;
    logic             req_valid, req_ready;
    logic [XLEN-1:0]  req_rs1, req_rs2;
    logic [2:0]       req_funct3;
    logic [TAG_W-1:0] req_rd;
    logic [XLEN-1:0]  mul_multiplier, mul_multiplicand, mul_data_out;
    logic [1:0]       mul_funct;
    logic             mul_valid_in;
    logic             wb_valid, wb_ready;
    logic [XLEN-1:0]  wb_data;
    logic [TAG_W-1:0] wb_rd;
    logic             busy;

    mul_issue_wb_ctrl #(.XLEN(XLEN), .TAG_W(TAG_W), .MUL_LAT(1), .RQ_DEPTH(RQ_DEPTH)) dut (
        .CLK(CLK), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_funct3(req_funct3), .req_rd(req_rd),
        .mul_multiplier(mul_multiplier), .mul_multiplicand(mul_multiplicand),
        .mul_funct(mul_funct), .mul_valid_in(mul_valid_in), .mul_data_out(mul_data_out),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
        .busy(busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // RISC-V M-extension multiply semantics.
    function automatic logic [31:0] ref_mul(input logic [1:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (f == 2'b11) ? {32'b0, a} : {{32{a[31]}}, a};
        eb = f[1] ? {32'b0, b} : {{32{b[31]}}, b};
        p  = ea * eb;
        return (f == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // External multiplier with one cycle of latency.
    always @(posedge CLK) if (mul_valid_in) mul_data_out <= ref_mul(mul_funct, mul_multiplier, mul_multiplicand);

    // Reference model: outstanding results in acceptance order, each tagged
    // with the cycle it becomes visible at writeback.
    typedef struct {
        int               rdy;
        logic [XLEN-1:0]  d;
        logic [TAG_W-1:0] rd;
    } exp_t;

    exp_t q[$];
    int   mcnt = 0;
    int   cyc = 0;
    bit   last_acc = 1'b0;
    int   checks = 0;
    int   failures = 0;

    // Advance one clock and apply the spec's rules to the model.
    task automatic cycle();
        bit   acc, pop;
        exp_t e;
        acc = req_valid && (mcnt < RQ_DEPTH) && !flush;
        pop = (q.size() > 0) && (q[0].rdy <= cyc) && wb_ready;
        @(posedge CLK);
        if (flush) begin
            q.delete();
            mcnt = 0;
        end else begin
            if (pop) begin
                e = q.pop_front();
                mcnt--;
            end
            if (acc) begin
                e.rdy = cyc + LAT_WB;
                e.d   = ref_mul(req_funct3[1:0], req_rs1, req_rs2);
                e.rd  = req_rd;
                q.push_back(e);
                mcnt++;
            end
        end
        last_acc = acc;
        cyc++;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; wb_ready = 1'b0;
        req_rs1 = '0; req_rs2 = '0; req_funct3 = '0; req_rd = '0;
        repeat (2) @(negedge CLK);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        checks++; if (mul_valid_in !== 1'b0) begin failures++; $display("FAIL reset_mul_valid got=%b exp=0", mul_valid_in); end
        checks++; if ({mul_multiplier, mul_multiplicand, mul_funct} !== '0) begin failures++; $display("FAIL reset_mul_ops got=%h/%h/%h exp=0", mul_multiplier, mul_multiplicand, mul_funct); end
        checks++; if ({wb_valid, wb_data, wb_rd, busy} !== '0) begin failures++; $display("FAIL reset_wb got v=%b d=%h rd=%h busy=%b exp=0", wb_valid, wb_data, wb_rd, busy); end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        wb_ready = 1'b1;
        req_valid = 1'b1; req_rs1 = 32'd7; req_rs2 = 32'd6; req_funct3 = 3'b000; req_rd = 5'd5;
        #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL single_ready got=%b exp=1", req_ready); end
        cycle();
        req_valid = 1'b0; #1;
        checks++; if ({mul_valid_in, mul_multiplier, mul_multiplicand, mul_funct} !== {1'b1, 32'd7, 32'd6, 2'b00})
            begin failures++; $display("FAIL single_issue got v=%b %0d/%0d f=%b exp v=1 7/6 f=00", mul_valid_in, mul_multiplier, mul_multiplicand, mul_funct); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", busy); end
        cycle(); #1;
        checks++; if ({mul_valid_in, wb_valid} !== 2'b00) begin failures++; $display("FAIL single_c2 got mv=%b wv=%b exp=00", mul_valid_in, wb_valid); end
        cycle(); #1;
        checks++; if ({wb_valid, wb_data, wb_rd} !== {1'b1, 32'd42, 5'd5})
            begin failures++; $display("FAIL single_wb got v=%b d=%0d rd=%0d exp v=1 d=42 rd=5", wb_valid, wb_data, wb_rd); end
        cycle(); #1;
        checks++; if ({busy, wb_valid} !== 2'b00) begin failures++; $display("FAIL single_idle got busy=%b wv=%b exp=00", busy, wb_valid); end
    endtask

    task automatic test_stream();
        wb_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            req_valid = (i < 8); req_rs1 = $urandom; req_rs2 = $urandom;
            req_funct3 = 3'($urandom); req_rd = TAG_W'(i + 1);
            #1;
            if (i < 8) begin
                checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL stream_ready c%0d got=%b exp=1", i, req_ready); end
            end
            checks++; if (mul_valid_in !== (i >= 1 && i <= 8)) begin failures++; $display("FAIL stream_issue c%0d got=%b exp=%b", i, mul_valid_in, (i >= 1 && i <= 8)); end
            checks++; if (wb_valid !== (i >= 3 && i <= 10)) begin failures++; $display("FAIL stream_wbv c%0d got=%b exp=%b", i, wb_valid, (i >= 3 && i <= 10)); end
            if (i >= 3 && i <= 10 && q.size() > 0) begin
                checks++; if (wb_rd !== TAG_W'(i - 2) || wb_data !== q[0].d)
                    begin failures++; $display("FAIL stream_wb c%0d got rd=%0d d=%h exp rd=%0d d=%h", i, wb_rd, wb_data, i - 2, q[0].d); end
            end
            cycle();
        end
    endtask

    task automatic test_backpressure();
        int               p, nacc;
        bit               have_first;
        logic [XLEN-1:0]  fd;
        logic [TAG_W-1:0] frd;
        p = 0; nacc = 0; have_first = 1'b0; fd = '0; frd = '0;
        wb_ready = 1'b0;
        req_rs1 = $urandom; req_rs2 = $urandom; req_funct3 = 3'($urandom); req_rd = 5'd16;
        for (int k = 0; k < 30; k++) begin
            if (k == 10) wb_ready = 1'b1;
            req_valid = (p < 6); req_rd = TAG_W'(16 + p);
            #1;
            checks++; if (req_ready !== (mcnt < RQ_DEPTH)) begin failures++; $display("FAIL bp_ready k%0d got=%b exp=%b", k, req_ready, (mcnt < RQ_DEPTH)); end
            if (!wb_ready && wb_valid) begin
                if (!have_first) begin fd = wb_data; frd = wb_rd; have_first = 1'b1; end
                else begin
                    checks++; if (wb_data !== fd || wb_rd !== frd) begin failures++; $display("FAIL bp_frozen k%0d got d=%h rd=%0d exp d=%h rd=%0d", k, wb_data, wb_rd, fd, frd); end
                end
            end
            if (wb_ready && q.size() > 0 && q[0].rdy <= cyc) begin
                checks++; if (wb_valid !== 1'b1 || wb_rd !== q[0].rd || wb_data !== q[0].d)
                    begin failures++; $display("FAIL bp_pop k%0d got v=%b rd=%0d d=%h exp rd=%0d d=%h", k, wb_valid, wb_rd, wb_data, q[0].rd, q[0].d); end
            end
            if (req_valid && req_ready) begin
                nacc++; p++;
                req_rs1 = $urandom; req_rs2 = $urandom; req_funct3 = 3'($urandom);
            end
            if (k == 9) begin
                checks++; if (nacc !== 4) begin failures++; $display("FAIL bp_accepted got=%0d exp=4", nacc); end
                checks++; if (!have_first) begin failures++; $display("FAIL bp_no_result got=0 exp=1"); end
            end
            cycle();
        end
        req_valid = 1'b0;
        checks++; if (nacc !== 6) begin failures++; $display("FAIL bp_total got=%0d exp=6", nacc); end
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_drain_busy got=%b exp=0", busy); end
    endtask

    task automatic test_pop_accept();
        wb_ready = 1'b0; req_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            req_rs1 = $urandom; req_rs2 = $urandom; req_funct3 = 3'($urandom); req_rd = TAG_W'($urandom);
            cycle();
        end
        wb_ready = 1'b1; #1;
        checks++; if ({req_ready, wb_valid} !== 2'b01) begin failures++; $display("FAIL pa_full got rdy=%b wv=%b exp rdy=0 wv=1", req_ready, wb_valid); end
        cycle(); #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL pa_credit got=%b exp=1", req_ready); end
        for (int k = 0; k < 12; k++) begin
            req_valid = (k < 4);
            req_rs1 = $urandom; req_rs2 = $urandom; req_funct3 = 3'($urandom); req_rd = TAG_W'($urandom);
            #1;
            checks++; if (req_ready !== (mcnt < RQ_DEPTH) || busy !== (mcnt != 0))
                begin failures++; $display("FAIL pa_cnt k%0d got rdy=%b busy=%b exp rdy=%b busy=%b", k, req_ready, busy, (mcnt < RQ_DEPTH), (mcnt != 0)); end
            if (q.size() > 0 && q[0].rdy <= cyc) begin
                checks++; if (wb_valid !== 1'b1 || wb_rd !== q[0].rd || wb_data !== q[0].d)
                    begin failures++; $display("FAIL pa_wb k%0d got v=%b rd=%0d d=%h exp rd=%0d d=%h", k, wb_valid, wb_rd, wb_data, q[0].rd, q[0].d); end
            end
            cycle();
        end
    endtask

    task automatic test_flush();
        int seen;
        wb_ready = 1'b0;
        req_valid = 1'b1; req_rs1 = 32'd3; req_rs2 = 32'd4; req_funct3 = 3'b000; req_rd = 5'd1;
        cycle();
        req_valid = 1'b0; cycle(); cycle(); #1;
        checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL flush_setup got=%b exp=1", wb_valid); end
        req_valid = 1'b1; req_rs1 = 32'd5; req_rd = 5'd2; cycle();
        req_rs1 = 32'd6; req_rd = 5'd3; cycle();
        flush = 1'b1; req_rs1 = 32'd9; req_rd = 5'd4; #1;
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%b exp=0", req_ready); end
        cycle();
        flush = 1'b0; req_valid = 1'b0; #1;
        checks++; if ({wb_valid, busy, mul_valid_in} !== 3'b000) begin failures++; $display("FAIL flush_clear got wv=%b busy=%b mv=%b exp=000", wb_valid, busy, mul_valid_in); end
        for (int k = 0; k < 5; k++) begin
            cycle(); #1;
            checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL flush_stale k%0d got=%b exp=0", k, wb_valid); end
        end
        wb_ready = 1'b1;
        req_valid = 1'b1; req_rs1 = 32'hFFFF_FFFE; req_rs2 = 32'd3; req_funct3 = 3'b001; req_rd = 5'd9;
        cycle();
        req_valid = 1'b0;
        seen = 0;
        for (int k = 0; k < 8 && seen == 0; k++) begin
            #1;
            if (wb_valid) begin
                seen = 1;
                checks++; if (wb_rd !== 5'd9 || wb_data !== 32'hFFFF_FFFF)
                    begin failures++; $display("FAIL flush_next got rd=%0d d=%h exp rd=9 d=ffffffff", wb_rd, wb_data); end
            end
            cycle();
        end
        checks++; if (seen == 0) begin failures++; $display("FAIL flush_next_timeout got=0 exp=1"); end
    endtask

    task automatic test_async_reset();
        wb_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            req_valid = 1'b1; req_rs1 = $urandom; req_rs2 = $urandom;
            req_funct3 = 3'($urandom); req_rd = TAG_W'($urandom);
            cycle();
        end
        req_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        checks++; if ({req_ready, mul_valid_in, mul_multiplier, mul_multiplicand, mul_funct} !== {1'b1, 1'b0, 66'b0})
            begin failures++; $display("FAIL areset_issue got rdy=%b mv=%b ops=%h/%h f=%b", req_ready, mul_valid_in, mul_multiplier, mul_multiplicand, mul_funct); end
        checks++; if ({wb_valid, wb_data, wb_rd, busy} !== '0)
            begin failures++; $display("FAIL areset_wb got v=%b d=%h rd=%h busy=%b exp=0", wb_valid, wb_data, wb_rd, busy); end
        q.delete(); mcnt = 0; last_acc = 1'b0;
        @(posedge CLK); cyc++;
        #2 rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle(); #1;
            checks++; if ({wb_valid, busy} !== 2'b00) begin failures++; $display("FAIL areset_residual k%0d got wv=%b busy=%b exp=00", k, wb_valid, busy); end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            req_valid  = ($urandom_range(0, 3) != 0);
            req_rs1    = $urandom; req_rs2 = $urandom;
            req_funct3 = 3'($urandom); req_rd = TAG_W'($urandom);
            wb_ready   = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 39) == 0);
            #1;
            checks++; if (req_ready !== (mcnt < RQ_DEPTH && !flush))
                begin failures++; $display("FAIL rnd_ready k%0d got=%b exp=%b", k, req_ready, (mcnt < RQ_DEPTH && !flush)); end
            checks++; if (busy !== (mcnt != 0)) begin failures++; $display("FAIL rnd_busy k%0d got=%b exp=%b", k, busy, (mcnt != 0)); end
            checks++; if (mul_valid_in !== last_acc) begin failures++; $display("FAIL rnd_issue k%0d got=%b exp=%b", k, mul_valid_in, last_acc); end
            checks++; if (wb_valid !== (q.size() > 0 && q[0].rdy <= cyc))
                begin failures++; $display("FAIL rnd_wbv k%0d got=%b exp=%b", k, wb_valid, (q.size() > 0 && q[0].rdy <= cyc)); end
            if (q.size() > 0 && q[0].rdy <= cyc) begin
                checks++; if (wb_rd !== q[0].rd || wb_data !== q[0].d)
                    begin failures++; $display("FAIL rnd_wb k%0d got rd=%0d d=%h exp rd=%0d d=%h", k, wb_rd, wb_data, q[0].rd, q[0].d); end
            end
            cycle();
        end
        flush = 1'b0; req_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_pop_accept();
        test_flush();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
